// File: rtl/sm_accum.sv
// sm_accum -- sequential sign-magnitude accumulator for the convolution datapath.
//
// Sums COUNT sign-magnitude terms plus a per-window bias and hands the window
// sum to the next stage over a valid/ready handshake. The bias is taken
// together with the first term of each window.
//
// Build option: define SM_ACCUM_SAT_EN to clamp the magnitude to all-ones on
// overflow. Without it, the magnitude wraps. In both builds ovf is set and stays
// set for the rest of the window.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous reset, active-high
//   in_data    sign-magnitude term (bit N-1 sign, N-2:0 magnitude)
//   in_valid   term present
//   in_ready   block can accept a term this cycle
//   bias_in    sign-magnitude bias, sampled with the first term of a window
//   out_data   window sum, sign-magnitude
//   out_valid  out_data holds a completed sum
//   out_ready  consumer accepts out_data
//   ovf        magnitude overflow occurred during the window (valid with out_valid)
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_ACCUM | accepting terms, in_ready = 1
// ST_DONE  | result held on out_data until out_ready, in_ready = 0
module sm_accum #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int COUNT = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] bias_in,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ovf
);

  localparam int M  = N - 1;
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  // Q only documents the fixed-point format; sign-magnitude addition ignores it.
  if (Q < 0 || Q > M || COUNT < 1 || COUNT > 65536) begin : g_param_check
    $error("sm_accum: illegal parameter value");
  end

  typedef enum logic {ST_ACCUM, ST_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  acc;
  logic          ovf_sticky;

  logic          accept;
  logic          last_term;
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_sum;
  logic          add_ovf;

  // Returns {overflow, sign, magnitude}.
  function automatic logic [N:0] smadd(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [M:0]   mag_sum;
    logic [M-1:0] a_mag;
    logic [M-1:0] b_mag;
    logic [M-1:0] mag;
    logic         sign;
    logic         of;
    a_mag   = a[M-1:0];
    b_mag   = b[M-1:0];
    mag_sum = '0;
    mag     = '0;
    sign    = 1'b0;
    of      = 1'b0;
    if (a[M] == b[M]) begin
      // Same sign: -0 + -0 stays -0 on purpose.
      mag_sum = {1'b0, a_mag} + {1'b0, b_mag};
      of      = mag_sum[M];
      sign    = a[M];
`ifdef SM_ACCUM_SAT_EN
      mag     = of ? '1 : mag_sum[M-1:0];
`else
      mag     = mag_sum[M-1:0];
`endif
    end else if (a_mag > b_mag) begin
      mag  = a_mag - b_mag;
      sign = a[M];
    end else begin
      // Exact cancellation always yields +0.
      mag  = b_mag - a_mag;
      sign = (mag == '0) ? 1'b0 : b[M];
    end
    return {of, sign, mag};
  endfunction

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);

  always_comb begin
    accept    = in_valid && (state == ST_ACCUM);
    last_term = (cnt == LAST);
    add_a     = (cnt == '0) ? bias_in : acc;
    {add_ovf, add_sum} = smadd(add_a, in_data);

    state_nxt = state;
    case (state)
      ST_ACCUM: if (accept && last_term) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)           state_nxt = ST_ACCUM;
      default:  state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACCUM;
      cnt        <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_data   <= '0;
      ovf        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (last_term) begin
          out_data   <= add_sum;
          ovf        <= ovf_sticky | add_ovf;
          cnt        <= '0;
          acc        <= add_sum;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= add_sum;
          cnt        <= cnt + CW'(1);
          // The first term restarts the sticky flag for the new window.
          ovf_sticky <= (cnt == '0) ? add_ovf : (ovf_sticky | add_ovf);
        end
      end else if (state == ST_DONE && out_ready) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm_accum.sv
module tb_sm_accum;

  localparam int N     = 32;
  localparam int COUNT = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  bias_in;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] terms [COUNT];
  logic [N-1:0] bias_v;
  logic [N-1:0] exp_data;
  logic         exp_ovf;
  logic [N-1:0] held;

  sm_accum #(.Q(15), .N(N), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bias_in(bias_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference addition done on signed integers; returns {ovf, result}.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint am, bm, va, vb, s, m, lim;
    logic [31:0] r;
    logic        of;
    lim = 64'sd2147483648;
    am  = longint'(a[30:0]);
    bm  = longint'(b[30:0]);
    va  = a[31] ? -am : am;
    vb  = b[31] ? -bm : bm;
    of  = 1'b0;
    if (a[31] == b[31]) begin
      m = am + bm;
      if (m >= lim) begin
        of = 1'b1;
`ifdef SM_ACCUM_SAT_EN
        m = lim - 1;
`else
        m = m - lim;
`endif
      end
      r = {a[31], m[30:0]};
    end else begin
      s = va + vb;
      m = (s < 0) ? -s : s;
      r = {(s < 0), m[30:0]};
    end
    return {of, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds terms[] with bias_v, computes the expected sum, checks latency.
  task automatic feed(input int max_gap);
    logic [32:0] r;
    logic [31:0] a;
    logic        st;
    int          gap;
    a  = bias_v;
    st = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      r  = ref_add(a, terms[i]);
      a  = r[31:0];
      st = st | r[32];
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        bias_in  = $urandom;
        step();
      end
      in_valid = 1'b1;
      in_data  = terms[i];
      bias_in  = (i == 0) ? bias_v : $urandom;
      chk("in_ready_accum", {31'b0, in_ready}, 32'd1);
      step();
      if (i < COUNT - 1) chk("no_early_valid", {31'b0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    chk("latency_valid", {31'b0, out_valid}, 32'd1);
    exp_data = a;
    exp_ovf  = st;
  endtask

  task automatic check_model();
    chk("sum_model", out_data, exp_data);
    chk("ovf_model", {31'b0, ovf}, {31'b0, exp_ovf});
  endtask

  task automatic pop(input int wait_cycles);
    held = out_data;
    out_ready = 1'b0;
    repeat (wait_cycles) begin
      step();
      chk("hold_data", out_data, held);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_valid", {31'b0, out_valid}, 32'd0);
    chk("pop_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic fill(input logic [31:0] b, input logic [31:0] first, input logic [31:0] rest);
    bias_v   = b;
    terms[0] = first;
    for (int i = 1; i < COUNT; i++) terms[i] = rest;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; bias_in = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    // Nine 1.0 terms back-to-back.
    fill(32'h0, 32'h0000_8000, 32'h0000_8000);
    feed(0);
    chk("d1_sum", out_data, 32'h0004_8000);
    chk("d1_ovf", {31'b0, ovf}, 32'd0);
    check_model();
    pop(0);

    // +0.5 + -1.0 = -0.5
    fill(32'h0000_4000, 32'h8000_8000, 32'h0);
    feed(0);
    chk("d2_sum", out_data, 32'h8000_4000);
    check_model();
    pop(1);

    // Exact cancellation gives +0.
    fill(32'h0000_8000, 32'h8000_8000, 32'h0);
    feed(0);
    chk("d3_tie", out_data, 32'h0000_0000);
    check_model();
    pop(0);

    // Overflow.
    fill(32'h7FFF_FFFF, 32'h0000_0001, 32'h0);
    feed(0);
`ifdef SM_ACCUM_SAT_EN
    chk("d4_sum", out_data, 32'h7FFF_FFFF);
`else
    chk("d4_sum", out_data, 32'h0000_0000);
`endif
    chk("d4_ovf", {31'b0, ovf}, 32'd1);
    check_model();
    pop(0);

    // Following window without overflow clears ovf.
    fill(32'h0, 32'h0000_8000, 32'h0000_8000);
    feed(0);
    chk("d5_ovf_clear", {31'b0, ovf}, 32'd0);
    chk("d5_sum", out_data, 32'h0004_8000);

    // Backpressure with in_valid held high: nothing consumed.
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    held     = out_data;
    repeat (5) begin
      step();
      chk("bp_data", out_data, held);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_pop", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < COUNT; i++) terms[i] = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 65535))};
    bias_v = $urandom;
    feed(0);
    check_model();
    pop(0);

    // Reset after 4 of 9 terms.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_8000;
      bias_in  = 32'h0001_0000;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ovf", {31'b0, ovf}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    fill(32'h0, 32'h0000_8000, 32'h0000_8000);
    feed(0);
    chk("mid_rst_sum", out_data, 32'h0004_8000);

    // Reset while DONE drops the result.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("done_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("done_rst_ready", {31'b0, in_ready}, 32'd1);

    // Randomized windows against the reference model.
    for (int w = 0; w < 24; w++) begin
      for (int i = 0; i < COUNT; i++) begin
        if ($urandom_range(0, 3) == 0)
          terms[i] = $urandom;
        else
          terms[i] = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 1 << 20))};
      end
      case ($urandom_range(0, 3))
        0: bias_v = {~terms[0][31], terms[0][30:0]};
        1: bias_v = {1'($urandom_range(0, 1)), 31'h7FFF_FFF0};
        default: bias_v = $urandom;
      endcase
      feed(2);
      check_model();
      pop($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sm_accum.md
Name: sm_accum

Overview:
- Sequential sign-magnitude fixed-point accumulator that sits directly downstream of the product stage in the convolution datapath.
- Consumes a stream of N-bit sign-magnitude products and sums COUNT of them, plus a per-window bias, using the team's sign-magnitude addition rules.
- Emits one result per window over a valid/ready handshake to the activation/pooling stage.

Parameters:
Q, 15, fractional bits; carried for format parity; does not change addition (sign-magnitude add is format-agnostic)
N, 32, total word width; bit N-1 = sign, bits N-2:0 = magnitude
COUNT, 9, terms per window (3x3 kernel); legal range 1..2^16

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  N  sign-magnitude term (product)
in_valid  input  1  term present
in_ready  output  1  block can accept a term this cycle
bias_in  input  N  sign-magnitude bias; sampled only with the first term of a window
out_data  output  N  window sum, sign-magnitude
out_valid  output  1  out_data holds a completed sum
out_ready  input  1  consumer accepts out_data
ovf  output  1  magnitude overflow occurred during this window; valid with out_valid

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: out_data = 0, out_valid = 0, ovf = 0, in_ready = 1, term counter = 0, accumulator = +0, state = ACCUM.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Term acceptance: a term is accepted on any edge with in_valid & in_ready.
- First term of a window (counter = 0): acc <= smadd(bias_in, in_data).
- Later terms: acc <= smadd(acc, in_data). Counter increments on each accepted term.
- On acceptance of the COUNT-th term, in the same edge:
  - out_data <= final sum, ovf <= sticky overflow OR this add's overflow
  - counter <= 0, state <= DONE
  - out_valid rises the cycle after the last accepted term (latency 1).
- DONE:
  - out_data and ovf held stable while out_ready = 0.
  - in_valid is ignored; no term is consumed.
  - On out_valid & out_ready: state <= ACCUM, sticky ovf cleared. A new term can be accepted the following cycle, giving a throughput of COUNT+1 cycles per window.
- smadd(a,b), magnitude width M = N-1:
  - Same sign: mag = a_mag + b_mag; sign = a sign (may yield -0; kept as is).
  - Different signs, a_mag > b_mag: mag = a_mag - b_mag, sign = a sign.
  - Different signs, a_mag <= b_mag: mag = b_mag - a_mag, sign = b sign, except mag == 0 gives sign 0 (ties produce +0).
  - Overflow: only possible on same-sign add, when the carry out of bit M-1 is set.
- -0 input: treated as magnitude 0 with its sign; no special case beyond the rules above.
- Reset mid-window: the partial sum is discarded, counter = 0; the next accepted term starts a new window and samples bias_in again.
- Reset in DONE: the pending result is dropped and out_valid = 0 on the next cycle.
- COUNT = 1: every accepted term completes a window; result = smadd(bias_in, term).

Optional Feature:
Macro SM_ACCUM_SAT_EN.
- Defined: on overflow, magnitude clamps to all-ones (2^(N-1)-1), sign kept, ovf set; later terms continue from the clamped value.
- Undefined: magnitude wraps modulo 2^(N-1), sign kept, ovf still set.
- Both: ovf is sticky for the window.

Test Plan:
- COUNT=9, bias 0x00000000, nine terms 0x00008000 (1.0) back-to-back -> out_data 0x00048000, ovf 0, out_valid exactly one cycle after the 9th accept.
- bias 0x00004000 (+0.5), first term 0x80008000 (-1.0), eight terms 0x00000000 -> out_data 0x80004000 (-0.5).
- bias 0x00008000, first term 0x80008000, eight zeros -> out_data 0x00000000 (tie gives +0, not 0x80000000).
- bias 0x7FFFFFFF, terms 0x00000001 then eight zeros:
  - without SAT_EN -> out_data 0x00000000, ovf 1
  - with SAT_EN -> out_data 0x7FFFFFFF, ovf 1
  - next window with no overflow -> ovf 0
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready 0, no terms consumed; after out_ready pulse the next window's sum uses only terms accepted afterward.
- Assert rst for 1 cycle after 4 of 9 terms -> all outputs at reset values; the next 9 terms of 0x00008000 with bias 0 give 0x00048000.
